// File: rtl/pi_bus_master_pkg.sv
// Shared PiStorm definitions: CPLD register map, command opcodes, ADDR_HI bit layout,
// master FSM encoding and the per-command phase tables.
package pi_bus_master_pkg;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_ADDR_LO = 2'd1;
   localparam logic [1:0] REG_ADDR_HI = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   localparam logic [1:0] OP_WRITE     = 2'd0;
   localparam logic [1:0] OP_READ      = 2'd1;
   localparam logic [1:0] OP_STATUS_WR = 2'd2;
   localparam logic [1:0] OP_STATUS_RD = 2'd3;

   localparam int ADDR_HI_READ_BIT = 9;
   localparam int ADDR_HI_BYTE_BIT = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;

   typedef enum logic [1:0] {
      STEP_ACCESS = 2'd0,
      STEP_WAIT   = 2'd1,
      STEP_DONE   = 2'd2
   } step_kind_t;

   typedef struct packed {
      logic [1:0] sel;
      logic       write;
   } access_t;

   // What kind of step sits at position idx of a command's phase list.
   function automatic step_kind_t step_kind(input logic [1:0] op, input logic [2:0] idx);
      step_kind_t k;
      k = STEP_DONE;
      case (op)
         OP_WRITE: begin
            if (idx <= 3'd2)      k = STEP_ACCESS;
            else if (idx == 3'd3) k = STEP_WAIT;
         end
         OP_READ: begin
            if (idx <= 3'd1)      k = STEP_ACCESS;
            else if (idx == 3'd2) k = STEP_WAIT;
            else if (idx == 3'd3) k = STEP_ACCESS;
         end
         default: begin
            if (idx == 3'd0) k = STEP_ACCESS;
         end
      endcase
      return k;
   endfunction

   // Register select and direction for an access step; don't-care for other steps.
   function automatic access_t step_access(input logic [1:0] op, input logic [2:0] idx);
      access_t a;
      a.sel   = REG_DATA;
      a.write = 1'b1;
      case (op)
         OP_WRITE: begin
            case (idx)
               3'd1:    a.sel = REG_ADDR_LO;
               3'd2:    a.sel = REG_ADDR_HI;
               default: a.sel = REG_DATA;
            endcase
         end
         OP_READ: begin
            case (idx)
               3'd0:    a.sel = REG_ADDR_LO;
               3'd1:    a.sel = REG_ADDR_HI;
               default: begin
                  a.sel   = REG_DATA;
                  a.write = 1'b0;
               end
            endcase
         end
         OP_STATUS_WR: a.sel = REG_STATUS;
         default: begin
            a.sel   = REG_STATUS;
            a.write = 1'b0;
         end
      endcase
      return a;
   endfunction

   function automatic logic [2:0] entry_state(input step_kind_t k);
      logic [2:0] s;
      case (k)
         STEP_ACCESS: s = ST_SETUP;
         STEP_WAIT:   s = ST_WAIT;
         default:     s = ST_RESP;
      endcase
      return s;
   endfunction

   function automatic logic [15:0] addr_hi_word(input logic is_read, input logic is_byte,
                                                input logic [7:0] addr_hi);
      logic [15:0] w;
      w = {8'h00, addr_hi};
      w[ADDR_HI_READ_BIT] = is_read;
      w[ADDR_HI_BYTE_BIT] = is_byte;
      return w;
   endfunction

endpackage

// File: rtl/pi_bus_master_access.sv
// Timing engine for one PI bus access: counts SETUP/STROBE/HOLD lengths and decodes
// the bus pins from the master's state. All phase lengths must be at least 1.
module pi_bus_access
   import pi_bus_master_pkg::*;
#(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  state,
   input  logic [1:0]  sel,
   input  logic        write,
   input  logic [15:0] wdata,
   output logic        phase_end,
   output logic        last_strobe,
   output logic [1:0]  pi_a,
   output logic        pi_wr,
   output logic        pi_rd,
   output logic [15:0] pi_d_out,
   output logic        pi_d_oe
);

   localparam int LEN_A   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int MAX_LEN = (LEN_A > HOLD_CYCLES) ? LEN_A : HOLD_CYCLES;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last_cnt;
   logic             in_access;

   assign in_access = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);

   always_comb begin
      last_cnt = '0;
      case (state)
         ST_SETUP:  last_cnt = CNT_W'(SETUP_CYCLES - 1);
         ST_STROBE: last_cnt = CNT_W'(STROBE_CYCLES - 1);
         ST_HOLD:   last_cnt = CNT_W'(HOLD_CYCLES - 1);
         default:   last_cnt = '0;
      endcase
   end

   assign phase_end   = in_access && (cnt == last_cnt);
   assign last_strobe = (state == ST_STROBE) && phase_end;

   // Every phase leaves on phase_end, so clearing there restarts the count for the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!in_access || phase_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign pi_a     = in_access ? sel : 2'd0;
   assign pi_d_oe  = in_access && write;
   assign pi_d_out = pi_d_oe ? wdata : 16'h0000;
   assign pi_wr    = (state == ST_STROBE) && write;
   assign pi_rd    = (state == ST_STROBE) && !write;

endmodule

// File: rtl/pi_bus_master.sv
// PiStorm PI bus master: accepts one 68k-style command, sequences its register
// accesses and busy wait, and returns a single-cycle response.
module pi_bus_master
   import pi_bus_master_pkg::*;
#(
   parameter int SETUP_CYCLES   = 1,
   parameter int STROBE_CYCLES  = 4,
   parameter int HOLD_CYCLES    = 1,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        PI_CLK,
   input  logic        PI_RST_n,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [1:0]  CMD_OP,
   input  logic        CMD_BYTE,
   input  logic [23:0] CMD_ADDR,
   input  logic [15:0] CMD_WDATA,
   output logic        RSP_VALID,
   output logic [15:0] RSP_RDATA,
   output logic        RSP_TIMEOUT,
   output logic [1:0]  PI_A,
   output logic        PI_WR,
   output logic        PI_RD,
   output logic [15:0] PI_D_OUT,
   output logic        PI_D_OE,
   input  logic [15:0] PI_D_IN,
   input  logic        PI_TXN_IN_PROGRESS
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [2:0]        state, state_next;
   logic [2:0]        idx, idx_next;
   logic [WAIT_W-1:0] wait_cnt, wait_next;
   logic [1:0]        op_reg;
   logic              byte_reg;
   logic [23:0]       addr_reg;
   logic [15:0]       wdata_reg;
   logic              txn_meta, txn_sync;
   logic [15:0]       cap_reg;
   logic [15:0]       rdata_reg;
   logic              timeout_reg;

   logic              accept;
   logic              phase_end;
   logic              last_strobe;
   logic              timed_out;
   logic              enter_resp;
   access_t           acc;
   step_kind_t        nxt_kind;
   logic [15:0]       bus_data;

   assign accept    = CMD_VALID && (state == ST_IDLE);
   assign CMD_READY = (state == ST_IDLE) && PI_RST_n;
   assign RSP_VALID = (state == ST_RESP);
   assign RSP_RDATA   = rdata_reg;
   assign RSP_TIMEOUT = timeout_reg;

   assign acc      = step_access(op_reg, idx);
   assign nxt_kind = step_kind(op_reg, idx + 3'd1);

   always_comb begin
      case (acc.sel)
         REG_ADDR_LO: bus_data = addr_reg[15:0];
         REG_ADDR_HI: bus_data = addr_hi_word(op_reg == OP_READ, byte_reg, addr_reg[23:16]);
         default:     bus_data = wdata_reg;
      endcase
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      wait_next  = '0;
      timed_out  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next = ST_SETUP;
               idx_next   = 3'd0;
            end
         end
         ST_SETUP: if (phase_end) state_next = ST_STROBE;
         ST_STROBE: if (phase_end) state_next = ST_HOLD;
         ST_HOLD: begin
            if (phase_end) begin
               idx_next   = idx + 3'd1;
               state_next = entry_state(nxt_kind);
            end
         end
         ST_WAIT: begin
            // The first three WAIT cycles cover the synchroniser lag on a freshly raised busy flag.
            if ((wait_cnt >= WAIT_W'(3)) && !txn_sync) begin
               idx_next   = idx + 3'd1;
               state_next = entry_state(nxt_kind);
            end else if (wait_cnt >= WAIT_W'(TIMEOUT_CYCLES - 1)) begin
               state_next = ST_RESP;
               timed_out  = 1'b1;
            end else begin
               wait_next = (&wait_cnt) ? wait_cnt : wait_cnt + WAIT_W'(1);
            end
         end
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign enter_resp = (state_next == ST_RESP) && (state != ST_RESP);

   always_ff @(posedge PI_CLK or negedge PI_RST_n) begin
      if (!PI_RST_n) begin
         txn_meta <= 1'b0;
         txn_sync <= 1'b0;
      end else begin
         txn_meta <= PI_TXN_IN_PROGRESS;
         txn_sync <= txn_meta;
      end
   end

   always_ff @(posedge PI_CLK or negedge PI_RST_n) begin
      if (!PI_RST_n) begin
         state       <= ST_IDLE;
         idx         <= 3'd0;
         wait_cnt    <= '0;
         op_reg      <= OP_WRITE;
         byte_reg    <= 1'b0;
         addr_reg    <= 24'h000000;
         wdata_reg   <= 16'h0000;
         cap_reg     <= 16'h0000;
         rdata_reg   <= 16'h0000;
         timeout_reg <= 1'b0;
      end else begin
         state    <= state_next;
         idx      <= idx_next;
         wait_cnt <= wait_next;
         if (accept) begin
            op_reg    <= CMD_OP;
            byte_reg  <= CMD_BYTE;
            addr_reg  <= CMD_ADDR;
            wdata_reg <= CMD_WDATA;
         end
         if (last_strobe && !acc.write) begin
            cap_reg <= PI_D_IN;
         end
         // A timed-out read never reached its DATA strobe, so its result is forced to zero.
         if (enter_resp) begin
            timeout_reg <= timed_out;
            rdata_reg   <= (!timed_out && ((op_reg == OP_READ) || (op_reg == OP_STATUS_RD)))
                           ? cap_reg : 16'h0000;
         end
      end
   end

   pi_bus_access #(
      .SETUP_CYCLES  (SETUP_CYCLES),
      .STROBE_CYCLES (STROBE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES)
   ) u_access (
      .clk         (PI_CLK),
      .rst_n       (PI_RST_n),
      .state       (state),
      .sel         (acc.sel),
      .write       (acc.write),
      .wdata       (bus_data),
      .phase_end   (phase_end),
      .last_strobe (last_strobe),
      .pi_a        (PI_A),
      .pi_wr       (PI_WR),
      .pi_rd       (PI_RD),
      .pi_d_out    (PI_D_OUT),
      .pi_d_oe     (PI_D_OE)
   );

endmodule
